// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule generator: loads 16 message words, then streams
// W[0..ROUNDS-1] using a 16-entry circular buffer updated in place.
module sha256_msg_sched #(
    parameter int ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        w_valid,
    input  logic        w_ready,
    output logic [31:0] w_data,
    output logic [5:0]  w_idx,
    output logic        w_last,
    output logic        busy
);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    state_t      state_q;
    logic [31:0] buf_q [16];
    logic [3:0]  lcnt_q;
    logic [5:0]  t_q;

    logic        run_s;
    logic [3:0]  slot_s;
    logic [31:0] w_calc_s;
    logic [31:0] w_word_s;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Schedule word for the current round; 4-bit slot arithmetic wraps mod 16.
    always_comb begin
        slot_s   = t_q[3:0];
        w_calc_s = sig1(buf_q[slot_s - 4'd2]) + buf_q[slot_s - 4'd7]
                 + sig0(buf_q[slot_s - 4'd15]) + buf_q[slot_s];
        if (t_q < 6'd16) begin
            w_word_s = buf_q[slot_s];
        end else begin
            w_word_s = w_calc_s;
        end
    end

    assign run_s    = (state_q == S_RUN);
    assign in_ready = !run_s;
    assign w_valid  = run_s;
    assign busy     = run_s;
    assign w_idx    = t_q;
    assign w_last   = run_s && (t_q == LAST_T);
    assign w_data   = run_s ? w_word_s : 32'd0;

    // Load/run controller with buffer write-back of computed words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LOAD;
            lcnt_q  <= 4'd0;
            t_q     <= 6'd0;
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= 32'd0;
            end
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (in_valid) begin
                        buf_q[lcnt_q] <= in_data;
                        lcnt_q        <= lcnt_q + 4'd1;
                        if (lcnt_q == 4'd15) begin
                            state_q <= S_RUN;
                            t_q     <= 6'd0;
                        end
                    end
                end
                S_RUN: begin
                    if (w_ready) begin
                        if (t_q >= 6'd16) begin
                            buf_q[slot_s] <= w_calc_s;
                        end
                        if (t_q == LAST_T) begin
                            state_q <= S_LOAD;
                            t_q     <= 6'd0;
                        end else begin
                            t_q <= t_q + 6'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Randomized self-checking bench for sha256_msg_sched (ROUNDS=64 and ROUNDS=16
// instances) against a full-array schedule model.
module tb_sha256_msg_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        w_ready;
    logic [31:0] in_data;
    logic        sel;

    always #5 clk = ~clk;

    logic        a_in_valid, a_w_ready, a_in_ready, a_w_valid, a_w_last, a_busy;
    logic [31:0] a_w_data;
    logic [5:0]  a_w_idx;
    logic        b_in_valid, b_w_ready, b_in_ready, b_w_valid, b_w_last, b_busy;
    logic [31:0] b_w_data;
    logic [5:0]  b_w_idx;

    assign a_in_valid = in_valid & ~sel;
    assign a_w_ready  = w_ready & ~sel;
    assign b_in_valid = in_valid & sel;
    assign b_w_ready  = w_ready & sel;

    sha256_msg_sched #(.ROUNDS(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .w_valid(a_w_valid), .w_ready(a_w_ready), .w_data(a_w_data),
        .w_idx(a_w_idx), .w_last(a_w_last), .busy(a_busy)
    );

    sha256_msg_sched #(.ROUNDS(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .w_valid(b_w_valid), .w_ready(b_w_ready), .w_data(b_w_data),
        .w_idx(b_w_idx), .w_last(b_w_last), .busy(b_busy)
    );

    logic        m_in_ready, m_w_valid, m_w_last, m_busy;
    logic [31:0] m_w_data;
    logic [5:0]  m_w_idx;

    assign m_in_ready = sel ? b_in_ready : a_in_ready;
    assign m_w_valid  = sel ? b_w_valid  : a_w_valid;
    assign m_w_last   = sel ? b_w_last   : a_w_last;
    assign m_busy     = sel ? b_busy     : a_busy;
    assign m_w_data   = sel ? b_w_data   : a_w_data;
    assign m_w_idx    = sel ? b_w_idx    : a_w_idx;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] msg   [16];
    logic [31:0] exp_w [64];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference: textbook schedule over a flat 64-entry array.
    function automatic void build_ref();
        for (int i = 0; i < 64; i++) begin
            if (i < 16) begin
                exp_w[i] = msg[i];
            end else begin
                exp_w[i] = (rr(exp_w[i-2], 17) ^ rr(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10))
                         + exp_w[i-7]
                         + (rr(exp_w[i-15], 7) ^ rr(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3))
                         + exp_w[i-16];
            end
        end
    endfunction

    task automatic set_abc();
        for (int i = 0; i < 16; i++) msg[i] = 32'd0;
        msg[0]  = 32'h61626380;
        msg[15] = 32'h00000018;
        build_ref();
    endtask

    task automatic set_zero();
        for (int i = 0; i < 16; i++) msg[i] = 32'd0;
        build_ref();
    endtask

    task automatic set_rand();
        for (int i = 0; i < 16; i++) msg[i] = $urandom;
        build_ref();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        w_ready  = 1'b0;
        #1;
        check("rst_async_in_ready", 32'(m_in_ready), 32'd1);
        check("rst_async_w_valid", 32'(m_w_valid), 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            w_ready  = 1'(($urandom_range(0, 1)));
            in_valid = 1'(($urandom_range(0, 1)));
            check("rst_in_ready", 32'(m_in_ready), 32'd1);
            check("rst_w_valid", 32'(m_w_valid), 32'd0);
            check("rst_w_last", 32'(m_w_last), 32'd0);
            check("rst_busy", 32'(m_busy), 32'd0);
            check("rst_w_idx", 32'(m_w_idx), 32'd0);
            check("rst_w_data", m_w_data, 32'd0);
        end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        w_ready  = 1'b0;
    endtask

    task automatic load_words(input int n, input bit gaps);
        int k = 0;
        int budget = 0;
        while (k < n && budget < 300) begin
            @(negedge clk);
            budget++;
            check("ld_in_ready", 32'(m_in_ready), 32'd1);
            check("ld_w_valid", 32'(m_w_valid), 32'd0);
            w_ready  = 1'(($urandom_range(0, 1)));
            in_valid = gaps ? 1'(($urandom_range(0, 1))) : 1'b1;
            in_data  = in_valid ? msg[k] : $urandom;
            if (in_valid) k++;
        end
        if (k < n) check("ld_timeout", 32'(k), 32'(n));
    endtask

    task automatic run_words(input int rounds, input bit bp, input bit junk, input int stop_at);
        int cnt = 0;
        int iters = 0;
        while (cnt < stop_at && iters < 1000) begin
            @(negedge clk);
            iters++;
            check("run_w_valid", 32'(m_w_valid), 32'd1);
            check("run_busy", 32'(m_busy), 32'd1);
            check("run_in_ready", 32'(m_in_ready), 32'd0);
            check("run_w_data", m_w_data, exp_w[cnt]);
            check("run_w_idx", 32'(m_w_idx), 32'(cnt));
            check("run_w_last", 32'(m_w_last), 32'(cnt == rounds - 1));
            w_ready  = bp ? 1'(($urandom_range(0, 1))) : 1'b1;
            in_valid = junk;
            in_data  = $urandom;
            if (w_ready) cnt++;
        end
        if (cnt < stop_at) check("run_timeout", 32'(cnt), 32'(stop_at));
        if (stop_at == rounds) begin
            @(negedge clk);
            in_valid = 1'b0;
            w_ready  = 1'b0;
            check("post_in_ready", 32'(m_in_ready), 32'd1);
            check("post_w_valid", 32'(m_w_valid), 32'd0);
            check("post_busy", 32'(m_busy), 32'd0);
            if (!bp) check("busy_cycles", 32'(iters), 32'(rounds));
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        w_ready  = 1'b0;
        in_data  = 32'd0;
        sel      = 1'b0;
        do_reset();

        set_abc();
        check("abc_model_w16", exp_w[16], 32'h61626380);
        check("abc_model_w17", exp_w[17], 32'h000F0000);
        load_words(16, 1'b0);
        run_words(64, 1'b0, 1'b0, 64);

        set_zero();
        load_words(16, 1'b0);
        run_words(64, 1'b0, 1'b0, 64);

        set_abc();
        load_words(16, 1'b1);
        run_words(64, 1'b1, 1'b0, 64);

        set_rand();
        load_words(16, 1'b0);
        run_words(64, 1'b0, 1'b1, 64);

        for (int b = 0; b < 4; b++) begin
            set_rand();
            load_words(16, 1'b1);
            run_words(64, 1'b1, (b % 2) == 1, 64);
        end

        set_rand();
        load_words(16, 1'b0);
        run_words(64, 1'b0, 1'b0, 20);
        do_reset();
        set_abc();
        load_words(16, 1'b0);
        run_words(64, 1'b0, 1'b0, 64);

        set_rand();
        load_words(7, 1'b1);
        do_reset();
        set_abc();
        load_words(16, 1'b1);
        run_words(64, 1'b1, 1'b0, 64);

        sel = 1'b1;
        do_reset();
        set_rand();
        load_words(16, 1'b0);
        run_words(16, 1'b0, 1'b0, 16);
        set_abc();
        load_words(16, 1'b1);
        run_words(16, 1'b1, 1'b1, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_msg_sched.md
SHA256_MSG_SCHED -- requirements
Module: sha256_msg_sched

Interface
REQ-001 The block SHALL have parameter ROUNDS, default 64: number of schedule words W[0..ROUNDS-1] emitted per block; legal range 16..64.
REQ-002 Port clk SHALL be an input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit: asynchronous, active-high reset.
REQ-004 Port in_valid SHALL be an input, 1 bit: in_data holds a message word.
REQ-005 Port in_ready SHALL be an output, 1 bit: block accepts a message word this cycle.
REQ-006 Port in_data SHALL be an input, 32 bits: message word, big-endian word order, W[0] first.
REQ-007 Port w_valid SHALL be an output, 1 bit: w_data/w_idx hold a schedule word.
REQ-008 Port w_ready SHALL be an input, 1 bit: consumer accepts the schedule word.
REQ-009 Port w_data SHALL be an output, 32 bits: schedule word W[w_idx].
REQ-010 Port w_idx SHALL be an output, 6 bits: index t of w_data.
REQ-011 Port w_last SHALL be an output, 1 bit: high with w_valid when w_idx = ROUNDS-1.
REQ-012 Port busy SHALL be an output, 1 bit: high whenever state is RUN.

Function
REQ-013 The block SHALL have two states: LOAD (in_ready=1, w_valid=0) and RUN (in_ready=0, w_valid=1).
REQ-014 The block SHALL hold a 16-entry x 32-bit circular buffer buf, a 4-bit load counter lcnt and a 6-bit round counter t.
REQ-015 In LOAD, each in_valid&&in_ready handshake SHALL write in_data to buf[lcnt] and increment lcnt.
REQ-016 The handshake with lcnt=15 SHALL move the block to RUN with t=0 and lcnt=0 on the next cycle; no bubble cycle is inserted.
REQ-017 In RUN, for t<16, w_data SHALL equal buf[t].
REQ-018 In RUN, for t>=16, w_data SHALL equal sig1(buf[(t-2)%16]) + buf[(t-7)%16] + sig0(buf[(t-15)%16]) + buf[t%16], summed modulo 2^32.
REQ-019 sig1(x) SHALL be ROTR17(x)^ROTR19(x)^SHR10(x) and sig0(x) SHALL be ROTR7(x)^ROTR18(x)^SHR3(x), all on 32-bit operands.
REQ-020 On each w_valid&&w_ready handshake with t>=16, the block SHALL write w_data into buf[t%16]; for t<16, buf SHALL be left unchanged.
REQ-021 Every w_valid&&w_ready handshake SHALL increment t; the handshake at t=ROUNDS-1 SHALL return the block to LOAD with t=0 on the next cycle.
REQ-022 w_data and w_idx SHALL be combinational from registered state only and stable while w_valid&&!w_ready (no dependence on w_ready).
REQ-023 Latency: the first schedule word SHALL be valid in the cycle after the 16th input handshake; with w_ready held at 1, one word is emitted per cycle.
REQ-024 in_valid asserted during RUN SHALL be ignored (in_ready=0, no buffer write).
REQ-025 w_ready asserted during LOAD SHALL have no effect.
REQ-026 Back-to-back blocks: in the cycle after the last w handshake, in_ready SHALL be 1 and the buffer SHALL be overwritten by the new block.

Reset
REQ-027 While rst=1, regardless of clk, the block SHALL force: state=LOAD, lcnt=0, t=0, all buf entries=0.
REQ-028 While rst=1, the outputs SHALL be in_ready=1, w_valid=0, w_last=0, busy=0, w_idx=0, w_data=0.
REQ-029 Reset asserted mid-LOAD or mid-RUN SHALL abandon the partial block; after release, the next accepted word SHALL be stored as W[0].

Verification
REQ-030 "abc" block: load W0=0x61626380, W1..W14=0, W15=0x00000018, with w_ready=1 -> W[0..15] echoed in order, W16=0x61626380, W17=0x000F0000, w_last high only at w_idx=63, then in_ready=1.
REQ-031 All-zero block -> all 64 words 0x00000000, w_idx 0..63 consecutive, busy high for exactly 64 cycles.
REQ-032 Random w_ready backpressure on the "abc" block -> identical word sequence, and w_data/w_idx stable during every stall cycle.
REQ-033 in_valid held high during RUN with changing in_data -> output sequence unchanged, no extra words loaded.
REQ-034 Assert rst at w_idx=20, then load the "abc" block -> W16=0x61626380, with no residue from the aborted block.
REQ-035 ROUNDS=16 build -> 16 words echoed, w_last at w_idx=15, no computed words.
